// File: rtl/instruction_controller.sv
// Fetch/decode control unit: holds PC and IR, sequences a Moore FSM
// that drives every register-file, ALU, mux and data-memory control.
module instruction_controller #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  output logic [PC_W-1:0]    I_addr,
  output logic               I_rd,
  input  logic [INSTR_W-1:0] I_data,
  output logic [7:0]         D_addr,
  output logic               D_wr,
  output logic [3:0]         RF_A_addr,
  output logic [3:0]         RF_B_addr,
  output logic [3:0]         RF_W_Addr,
  output logic               RF_W_en,
  output logic [2:0]         ALU_s,
  output logic               MuxSel,
  output logic [PC_W-1:0]    PC_out,
  output logic [INSTR_W-1:0] IR_out,
  output logic [3:0]         State_out
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t state;
  state_t nxt;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;

  logic [3:0] op_new;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;
  logic [7:0] addr;

  assign op_new = I_data[15:12];
  assign ra     = ir[11:8];
  assign rb     = ir[7:4];
  assign rd     = ir[3:0];
  assign addr   = ir[7:0];

  assign PC_out    = pc;
  assign IR_out    = ir;
  assign State_out = state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (state == S_FETCH)
        pc <= pc + PC_ONE;
      if (state == S_DECODE)
        ir <= I_data;
    end
  end

  // Dispatch on the freshly fetched word; IR only loads at this edge.
  always_comb begin
    nxt = state;
    unique case (state)
      S_INIT:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        nxt = S_NOOP;
        unique case (1'b1)
          (op_new == 4'h1): nxt = S_STORE;
          (op_new == 4'h2): nxt = S_LOAD_A;
          (op_new == 4'h3): nxt = S_ADD;
          (op_new == 4'h4): nxt = S_SUB;
          (op_new == 4'h5): nxt = S_HALT;
          default:          nxt = S_NOOP;
        endcase
      end
      S_LOAD_A: nxt = S_LOAD_B;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    I_addr    = '0;
    I_rd      = 1'b0;
    D_addr    = '0;
    D_wr      = 1'b0;
    RF_A_addr = '0;
    RF_B_addr = '0;
    RF_W_Addr = '0;
    RF_W_en   = 1'b0;
    ALU_s     = 3'b000;
    MuxSel    = 1'b0;
    unique case (state)
      S_FETCH: begin
        I_rd   = 1'b1;
        I_addr = pc;
      end
      S_STORE: begin
        RF_A_addr = ra;
        D_addr    = addr;
        D_wr      = 1'b1;
      end
      S_LOAD_A: begin
        D_addr = addr;
        MuxSel = 1'b1;
      end
      // LOAD destination sits in the ra field.
      S_LOAD_B: begin
        D_addr    = addr;
        MuxSel    = 1'b1;
        RF_W_Addr = ra;
        RF_W_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_A_addr = ra;
        RF_B_addr = rb;
        RF_W_Addr = rd;
        RF_W_en   = 1'b1;
        ALU_s     = (state == S_ADD) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instruction_controller.sv
// Bench for instruction_controller: ROM model, per-cycle scoreboard
// of expected control vectors, reset and wrap scenarios.
module tb_instruction_controller;

  logic        CLK;
  logic        RESET_N;
  logic [6:0]  I_addr;
  logic        I_rd;
  logic [15:0] I_data;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic [3:0]  RF_A_addr;
  logic [3:0]  RF_B_addr;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [2:0]  ALU_s;
  logic        MuxSel;
  logic [6:0]  PC_out;
  logic [15:0] IR_out;
  logic [3:0]  State_out;

  instruction_controller #(.PC_W(7), .INSTR_W(16)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .I_addr(I_addr),
    .I_rd(I_rd),
    .I_data(I_data),
    .D_addr(D_addr),
    .D_wr(D_wr),
    .RF_A_addr(RF_A_addr),
    .RF_B_addr(RF_B_addr),
    .RF_W_Addr(RF_W_Addr),
    .RF_W_en(RF_W_en),
    .ALU_s(ALU_s),
    .MuxSel(MuxSel),
    .PC_out(PC_out),
    .IR_out(IR_out),
    .State_out(State_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] rom [128];
  initial I_data = '0;
  always @(posedge CLK)
    if (I_rd) I_data <= rom[I_addr];

  int checks;
  int failures;
  int excl;
  int wen_seen;
  bit watch;
  logic [63:0] sb [$];
  logic [6:0]  mpc;
  logic [15:0] mir;

  always @(negedge CLK)
    if (RF_W_en && D_wr) excl++;
  always @(posedge RF_W_en)
    if (watch) wen_seen++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(
    input logic [3:0] st, input logic ird, input logic [6:0] ia,
    input logic [7:0] da, input logic dwr, input logic [3:0] a,
    input logic [3:0] b, input logic [3:0] w, input logic wen,
    input logic [2:0] alu, input logic mux, input logic [6:0] p,
    input logic [15:0] i);
    return {3'b0, st, ird, ia, da, dwr, a, b, w, wen, alu, mux, p, i};
  endfunction

  function automatic logic [63:0] obs();
    return mk(State_out, I_rd, I_addr, D_addr, D_wr, RF_A_addr,
              RF_B_addr, RF_W_Addr, RF_W_en, ALU_s, MuxSel,
              PC_out, IR_out);
  endfunction

  // Push expected cycles for n instructions from the model PC; stops
  // at HALT after queueing hold cycles.
  task automatic push_prog(input int n, input bit tail_fetch);
    logic [15:0] w;
    logic [6:0]  np;
    for (int k = 0; k < n; k++) begin
      w  = rom[mpc];
      np = mpc + 7'd1;
      sb.push_back(mk(4'd1, 1, mpc, 0, 0, 0, 0, 0, 0, 0, 0, mpc, mir));
      sb.push_back(mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, np, mir));
      case (w[15:12])
        4'h1: sb.push_back(mk(4'd6, 0, 0, w[7:0], 1, w[11:8], 0, 0,
                              0, 0, 0, np, w));
        4'h2: begin
          sb.push_back(mk(4'd4, 0, 0, w[7:0], 0, 0, 0, 0, 0, 0, 1,
                          np, w));
          sb.push_back(mk(4'd5, 0, 0, w[7:0], 0, 0, 0, w[11:8], 1,
                          0, 1, np, w));
        end
        4'h3: sb.push_back(mk(4'd7, 0, 0, 0, 0, w[11:8], w[7:4],
                              w[3:0], 1, 3'b001, 0, np, w));
        4'h4: sb.push_back(mk(4'd8, 0, 0, 0, 0, w[11:8], w[7:4],
                              w[3:0], 1, 3'b010, 0, np, w));
        4'h5: begin
          for (int h = 0; h < 22; h++)
            sb.push_back(mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, np, w));
          return;
        end
        default: sb.push_back(mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                 np, w));
      endcase
      mpc = np;
      mir = w;
    end
    if (tail_fetch)
      sb.push_back(mk(4'd1, 1, mpc, 0, 0, 0, 0, 0, 0, 0, 0, mpc, mir));
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_vec", obs(), 64'd0);
    mpc = '0;
    mir = '0;
    sb.delete();
  endtask

  task automatic drain(input string tag);
    logic [63:0] e;
    RESET_N = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge CLK);
      chk(tag, obs(), e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    excl     = 0;
    wen_seen = 0;
    watch    = 0;
    RESET_N  = 1'b0;
    foreach (rom[i]) rom[i] = '0;

    // LOAD, ADD, SUB, ADD with rd == ra, HALT
    do_reset();
    rom[0] = 16'h2305;
    rom[1] = 16'h3124;
    rom[2] = 16'h4124;
    rom[3] = 16'h3535;
    rom[4] = 16'h5000;
    push_prog(5, 0);
    drain("prog_a");
    chk("halt_pc", {57'd0, PC_out}, 64'd5);

    // STORE then HALT
    foreach (rom[i]) rom[i] = '0;
    do_reset();
    rom[0] = 16'h1710;
    rom[1] = 16'h5000;
    push_prog(2, 0);
    drain("prog_b");
    chk("halt_pc2", {57'd0, PC_out}, 64'd2);

    // 127 NOOPs, illegal opcode at 127, wrap back to 0
    foreach (rom[i]) rom[i] = '0;
    rom[127] = 16'hF000;
    do_reset();
    push_prog(128, 1);
    drain("wrap");
    chk("wrap_pc", {57'd0, PC_out}, 64'd0);

    // Asynchronous reset during LOAD_A
    foreach (rom[i]) rom[i] = '0;
    rom[0] = 16'h2305;
    do_reset();
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("in_load_a", {60'd0, State_out}, 64'd4);
    watch = 1;
    #2 RESET_N = 1'b0;
    #1 chk("async_vec", obs(), 64'd0);
    repeat (3) @(negedge CLK);
    chk("held_vec", obs(), 64'd0);
    watch = 0;
    chk("no_wen", wen_seen, 0);
    chk("excl", excl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
